// File: rtl/kasumi_pkg.sv
// Shared types and constants for the Kasumi core memory/write-back stage.
// Holds the stage FSM encoding, RV32I funct3 width codes and the
// misalignment predicate used when MISALIGN_CHECK_EN is defined.
package kasumi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    WB   = 2'd3
  } state_e;

  // Load widths
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store widths
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // True when the low address bits are not aligned to the access width.
  // Unknown load widths behave as LW and unknown store widths as SW.
  function automatic logic is_misaligned(input logic       is_load,
                                         input logic [2:0] funct3,
                                         input logic [1:0] a);
    logic bad;
    bad = 1'b0;
    if (is_load) begin
      case (funct3)
        F3_LB, F3_LBU: bad = 1'b0;
        F3_LH, F3_LHU: bad = a[0];
        default:       bad = (a != 2'b00);
      endcase
    end else begin
      case (funct3)
        F3_SB:   bad = 1'b0;
        F3_SH:   bad = a[0];
        default: bad = (a != 2'b00);
      endcase
    end
    return bad;
  endfunction

endpackage

// File: rtl/mem_wb_stage_lsu_align.sv
// lsu_align: combinational byte-lane handling for the memory stage.
// Load side picks the addressed byte/half out of the read word and
// sign/zero extends it; store side builds the byte strobes and the
// lane-replicated write data. Word accesses ignore the low address bits.
module lsu_align
  import kasumi_pkg::*;
(
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_a,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data,
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_a,
  input  logic [31:0] st_data,
  output logic [3:0]  st_wstrb,
  output logic [31:0] st_wdata
);

  logic [7:0]  ld_byte_s;
  logic [15:0] ld_half_s;

  // Load lane select followed by width/sign extension
  always_comb begin
    ld_byte_s = 8'h00;
    ld_half_s = 16'h0000;
    ld_data   = 32'h0000_0000;
    case (ld_a)
      2'd0:    ld_byte_s = ld_rdata[7:0];
      2'd1:    ld_byte_s = ld_rdata[15:8];
      2'd2:    ld_byte_s = ld_rdata[23:16];
      2'd3:    ld_byte_s = ld_rdata[31:24];
      default: ld_byte_s = 8'h00;
    endcase
    if (ld_a[1]) begin
      ld_half_s = ld_rdata[31:16];
    end else begin
      ld_half_s = ld_rdata[15:0];
    end
    case (ld_funct3)
      F3_LB:   ld_data = {{24{ld_byte_s[7]}}, ld_byte_s};
      F3_LBU:  ld_data = {24'h00_0000, ld_byte_s};
      F3_LH:   ld_data = {{16{ld_half_s[15]}}, ld_half_s};
      F3_LHU:  ld_data = {16'h0000, ld_half_s};
      default: ld_data = ld_rdata;
    endcase
  end

  // Store strobes and replicated data so any lane sees the right bytes
  always_comb begin
    st_wstrb = 4'b0000;
    st_wdata = 32'h0000_0000;
    case (st_funct3)
      F3_SB: begin
        st_wstrb = 4'b0001 << st_a;
        st_wdata = {4{st_data[7:0]}};
      end
      F3_SH: begin
        if (st_a[1]) begin
          st_wstrb = 4'b1100;
        end else begin
          st_wstrb = 4'b0011;
        end
        st_wdata = {2{st_data[15:0]}};
      end
      default: begin
        st_wstrb = 4'b1111;
        st_wdata = st_data;
      end
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory-access and write-back stage of the Kasumi core.
// Accepts one EX result at a time, runs loads/stores over a valid/ready
// data-memory port and drives the register-file write port.
// Optional feature macro: MISALIGN_CHECK_EN (faults misaligned LH/LHU/SH
// and LW/SW instead of issuing them; undefined by default).
module mem_wb_stage
  import kasumi_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic            ex_rd_we,
  input  logic [4:0]      ex_rd_addr,
  input  logic            ex_is_load,
  input  logic            ex_is_store,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_alu_result,
  input  logic [XLEN-1:0] ex_store_data,
  output logic            dmem_req_valid,
  input  logic            dmem_req_ready,
  output logic [XLEN-1:0] dmem_addr,
  output logic            dmem_we,
  output logic [3:0]      dmem_wstrb,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_rsp_valid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            is_write,
  output logic [4:0]      wb_addr,
  output logic [XLEN-1:0] wb_data,
  output logic            misalign_fault
);

  state_e            state_q, state_d;
  logic              is_load_q, is_load_d;
  logic              rd_we_q, rd_we_d;
  logic [4:0]        rd_addr_q, rd_addr_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        a_q, a_d;
  logic              req_valid_q, req_valid_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic              we_q, we_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              is_write_q, is_write_d;
  logic [4:0]        wb_addr_q, wb_addr_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d;
  logic              fault_q, fault_d;

  logic              ex_ready_s;
  logic              accept_s;
  logic              misalign_s;
  logic              mem_op_s;
  logic [XLEN-1:0]   ld_data_s;
  logic [3:0]        st_wstrb_s;
  logic [XLEN-1:0]   st_wdata_s;

  // Store side uses the incoming instruction, load side the captured one
  lsu_align u_lsu_align (
    .ld_funct3 (funct3_q),
    .ld_a      (a_q),
    .ld_rdata  (dmem_rdata),
    .ld_data   (ld_data_s),
    .st_funct3 (ex_funct3),
    .st_a      (ex_alu_result[1:0]),
    .st_data   (ex_store_data),
    .st_wstrb  (st_wstrb_s),
    .st_wdata  (st_wdata_s)
  );

  assign mem_op_s   = ex_is_load | ex_is_store;
  assign ex_ready_s = ~rst & ((state_q == IDLE) | (state_q == WB));
  assign accept_s   = ex_valid & ex_ready_s;

`ifdef MISALIGN_CHECK_EN
  assign misalign_s = mem_op_s & is_misaligned(ex_is_load, ex_funct3, ex_alu_result[1:0]);
`else
  assign misalign_s = 1'b0;
`endif

  // Next-state and next-output logic for the stage FSM
  always_comb begin
    state_d     = state_q;
    is_load_d   = is_load_q;
    rd_we_d     = rd_we_q;
    rd_addr_d   = rd_addr_q;
    funct3_d    = funct3_q;
    a_d         = a_q;
    req_valid_d = req_valid_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wstrb_d     = wstrb_q;
    wdata_d     = wdata_q;
    is_write_d  = 1'b0;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    fault_d     = 1'b0;

    case (state_q)
      IDLE, WB: begin
        // WB lasts one cycle unless a new instruction takes over
        state_d = IDLE;
        if (accept_s) begin
          is_load_d = ex_is_load;
          rd_we_d   = ex_rd_we;
          rd_addr_d = ex_rd_addr;
          funct3_d  = ex_funct3;
          a_d       = ex_alu_result[1:0];
          if (mem_op_s) begin
            if (misalign_s) begin
              state_d = IDLE;
              fault_d = 1'b1;
            end else begin
              state_d     = REQ;
              req_valid_d = 1'b1;
              addr_d      = {ex_alu_result[XLEN-1:2], 2'b00};
              we_d        = ex_is_store & ~ex_is_load;
              if (ex_is_store & ~ex_is_load) begin
                wstrb_d = st_wstrb_s;
                wdata_d = st_wdata_s;
              end else begin
                wstrb_d = 4'b0000;
                wdata_d = {XLEN{1'b0}};
              end
            end
          end else begin
            state_d    = WB;
            is_write_d = ex_rd_we;
            wb_addr_d  = ex_rd_addr;
            wb_data_d  = ex_alu_result;
          end
        end else begin
          state_d = IDLE;
        end
      end

      REQ: begin
        if (dmem_req_ready) begin
          req_valid_d = 1'b0;
          addr_d      = {XLEN{1'b0}};
          we_d        = 1'b0;
          wstrb_d     = 4'b0000;
          wdata_d     = {XLEN{1'b0}};
          if (is_load_q) begin
            state_d = WAIT;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = REQ;
        end
      end

      WAIT: begin
        if (dmem_rsp_valid) begin
          state_d    = WB;
          is_write_d = rd_we_q;
          wb_addr_d  = rd_addr_q;
          wb_data_d  = ld_data_s;
        end else begin
          state_d = WAIT;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      is_load_q   <= 1'b0;
      rd_we_q     <= 1'b0;
      rd_addr_q   <= 5'd0;
      funct3_q    <= 3'd0;
      a_q         <= 2'd0;
      req_valid_q <= 1'b0;
      addr_q      <= {XLEN{1'b0}};
      we_q        <= 1'b0;
      wstrb_q     <= 4'b0000;
      wdata_q     <= {XLEN{1'b0}};
      is_write_q  <= 1'b0;
      wb_addr_q   <= 5'd0;
      wb_data_q   <= {XLEN{1'b0}};
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_load_q   <= is_load_d;
      rd_we_q     <= rd_we_d;
      rd_addr_q   <= rd_addr_d;
      funct3_q    <= funct3_d;
      a_q         <= a_d;
      req_valid_q <= req_valid_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wstrb_q     <= wstrb_d;
      wdata_q     <= wdata_d;
      is_write_q  <= is_write_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      fault_q     <= fault_d;
    end
  end

  assign ex_ready       = ex_ready_s;
  assign dmem_req_valid = req_valid_q;
  assign dmem_addr      = addr_q;
  assign dmem_we        = we_q;
  assign dmem_wstrb     = wstrb_q;
  assign dmem_wdata     = wdata_q;
  assign is_write       = is_write_q;
  assign wb_addr        = wb_addr_q;
  assign wb_data        = wb_data_q;
  assign misalign_fault = fault_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed vector table, hand-written
// multi-cycle sequences and randomized loads/stores/ALU ops checked against
// a behavioural model of the RV32I lane rules.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_ready, ex_rd_we, ex_is_load, ex_is_store;
  logic [4:0]  ex_rd_addr;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_alu_result, ex_store_data;
  logic        dmem_req_valid, dmem_req_ready, dmem_we, dmem_rsp_valid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;
  logic        is_write, misalign_fault;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd_we(ex_rd_we),
    .ex_rd_addr(ex_rd_addr), .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
    .ex_funct3(ex_funct3), .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_wstrb(dmem_wstrb),
    .dmem_wdata(dmem_wdata), .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata),
    .is_write(is_write), .wb_addr(wb_addr), .wb_data(wb_data),
    .misalign_fault(misalign_fault)
  );

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] word;
    logic        we;
    logic [4:0]  rd;
    int          rdy_dly;
    int          rsp_dly;
    logic [31:0] exp_addr;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;
    logic [31:0] exp_wb;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  // Reference model: lane rules as plain arithmetic
  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] w);
    logic [31:0] v;
    if (f3 == 3'd0 || f3 == 3'd4) begin
      v = (w >> (8 * a)) & 32'h0000_00FF;
      if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
    end else if (f3 == 3'd1 || f3 == 3'd5) begin
      v = (w >> (16 * (a / 2))) & 32'h0000_FFFF;
      if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [1:0] a);
    if (f3 == 3'd0) return 4'd1 << a;
    if (f3 == 3'd1) return 4'd3 << (2 * (a / 2));
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (f3 == 3'd0) return (d & 32'h0000_00FF) * 32'h0101_0101;
    if (f3 == 3'd1) return (d & 32'h0000_FFFF) * 32'h0001_0001;
    return d;
  endfunction

  // Present one instruction at a negedge and hold it for one cycle
  task automatic present(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] sdata,
                         input logic we, input logic [4:0] rd);
    int guard;
    guard = 0;
    while (ex_ready !== 1'b1 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    if (guard == 10) chk("ex_ready_timeout", {31'd0, ex_ready}, 32'd1);
    ex_valid = 1'b1; ex_is_load = ld; ex_is_store = st; ex_funct3 = f3;
    ex_alu_result = alu; ex_store_data = sdata; ex_rd_we = we; ex_rd_addr = rd;
    @(negedge clk);
    ex_valid = 1'b0;
  endtask

  // Full single-instruction transaction with memory-side responder
  task automatic run_op(input vec_t v);
    present(v.ld, v.st, v.f3, v.addr, v.sdata, v.we, v.rd);
    chk("fault_low", {31'd0, misalign_fault}, 32'd0);
    if (v.ld || v.st) begin
      chk("req_ex_ready", {31'd0, ex_ready}, 32'd0);
      for (int k = 0; k <= v.rdy_dly; k++) begin
        if (k > 0) @(negedge clk);
        chk("req_valid", {31'd0, dmem_req_valid}, 32'd1);
        chk("req_addr", dmem_addr, v.exp_addr);
        chk("req_we", {31'd0, dmem_we}, {31'd0, v.st});
        chk("req_wstrb", {28'd0, dmem_wstrb}, {28'd0, v.exp_wstrb});
        chk("req_wdata", dmem_wdata, v.exp_wdata);
      end
      dmem_req_ready = 1'b1;
      @(negedge clk);
      dmem_req_ready = 1'b0;
      chk("req_dropped", {31'd0, dmem_req_valid}, 32'd0);
      chk("we_idle", {31'd0, dmem_we}, 32'd0);
      if (v.st) begin
        chk("store_ex_ready", {31'd0, ex_ready}, 32'd1);
        chk("store_no_write", {31'd0, is_write}, 32'd0);
      end else begin
        for (int k = 1; k < v.rsp_dly; k++) begin
          chk("wait_no_write", {31'd0, is_write}, 32'd0);
          @(negedge clk);
        end
        dmem_rsp_valid = 1'b1; dmem_rdata = v.word;
        @(negedge clk);
        dmem_rsp_valid = 1'b0; dmem_rdata = 32'hDEAD_0000;
        chk("ld_is_write", {31'd0, is_write}, {31'd0, v.we});
        if (v.we) chk("ld_wb_addr", {27'd0, wb_addr}, {27'd0, v.rd});
        chk("ld_wb_data", wb_data, v.exp_wb);
      end
    end else begin
      chk("alu_is_write", {31'd0, is_write}, {31'd0, v.we});
      if (v.we) chk("alu_wb_addr", {27'd0, wb_addr}, {27'd0, v.rd});
      chk("alu_wb_data", wb_data, v.exp_wb);
    end
    @(negedge clk);
    chk("write_one_cycle", {31'd0, is_write}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF_1234, 1'b1, 5'd7, 0, 2, 32'h100, 4'h0, 32'h0, 32'hFFFF_FF80};
    tbl[1]  = '{1'b1, 1'b0, 3'd4, 32'h103, 32'h0, 32'h80FF_1234, 1'b1, 5'd7, 0, 2, 32'h100, 4'h0, 32'h0, 32'h0000_0080};
    tbl[2]  = '{1'b1, 1'b0, 3'd1, 32'h202, 32'h0, 32'h8001_7FFF, 1'b1, 5'd8, 1, 1, 32'h200, 4'h0, 32'h0, 32'hFFFF_8001};
    tbl[3]  = '{1'b1, 1'b0, 3'd5, 32'h202, 32'h0, 32'h8001_7FFF, 1'b1, 5'd8, 0, 3, 32'h200, 4'h0, 32'h0, 32'h0000_8001};
    tbl[4]  = '{1'b0, 1'b1, 3'd0, 32'h301, 32'h0000_00AB, 32'h0, 1'b0, 5'd0, 3, 1, 32'h300, 4'b0010, 32'hABAB_ABAB, 32'h0};
    tbl[5]  = '{1'b0, 1'b1, 3'd1, 32'h302, 32'h1234_CDEF, 32'h0, 1'b0, 5'd0, 0, 1, 32'h300, 4'b1100, 32'hCDEF_CDEF, 32'h0};
    tbl[6]  = '{1'b0, 1'b1, 3'd2, 32'h500, 32'hCAFE_F00D, 32'h0, 1'b0, 5'd0, 1, 1, 32'h500, 4'b1111, 32'hCAFE_F00D, 32'h0};
    tbl[7]  = '{1'b1, 1'b0, 3'd2, 32'h404, 32'h0, 32'h1234_5678, 1'b1, 5'd9, 0, 1, 32'h404, 4'h0, 32'h0, 32'h1234_5678};
    tbl[8]  = '{1'b0, 1'b0, 3'd0, 32'hA5A5_0001, 32'h0, 32'h0, 1'b1, 5'd3, 0, 0, 32'h0, 4'h0, 32'h0, 32'hA5A5_0001};
    tbl[9]  = '{1'b0, 1'b0, 3'd0, 32'h0000_BEEF, 32'h0, 32'h0, 1'b0, 5'd4, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0000_BEEF};
    tbl[10] = '{1'b1, 1'b0, 3'd0, 32'h100, 32'h0, 32'h0000_007F, 1'b1, 5'd10, 0, 1, 32'h100, 4'h0, 32'h0, 32'h0000_007F};
    tbl[11] = '{1'b1, 1'b0, 3'd1, 32'h200, 32'h0, 32'h0000_FFFF, 1'b1, 5'd11, 0, 2, 32'h200, 4'h0, 32'h0, 32'hFFFF_FFFF};

    rst = 1'b1; ex_valid = 1'b0; ex_rd_we = 1'b0; ex_rd_addr = 5'd0;
    ex_is_load = 1'b0; ex_is_store = 1'b0; ex_funct3 = 3'd0;
    ex_alu_result = 32'd0; ex_store_data = 32'd0;
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rdata = 32'd0;

    // Reset with an ALU op offered: reset wins
    @(negedge clk);
    ex_valid = 1'b1; ex_rd_we = 1'b1; ex_rd_addr = 5'd1; ex_alu_result = 32'h5555_5555;
    repeat (2) @(negedge clk);
    chk("rst_ex_ready", {31'd0, ex_ready}, 32'd0);
    chk("rst_req_valid", {31'd0, dmem_req_valid}, 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_wstrb", {28'd0, dmem_wstrb}, 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    chk("rst_is_write", {31'd0, is_write}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_addr", {27'd0, wb_addr}, 32'd0);
    chk("rst_fault", {31'd0, misalign_fault}, 32'd0);
    ex_valid = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, ex_ready}, 32'd1);
    chk("post_rst_no_write", {31'd0, is_write}, 32'd0);

    // Directed vector table
    for (int i = 0; i < 12; i++) run_op(tbl[i]);

    // Back-to-back ALU ops: one per cycle
    @(negedge clk);
    ex_valid = 1'b1; ex_is_load = 1'b0; ex_is_store = 1'b0; ex_rd_we = 1'b1;
    ex_rd_addr = 5'd5; ex_alu_result = 32'h11;
    @(negedge clk);
    chk("b2b_ready", {31'd0, ex_ready}, 32'd1);
    chk("b2b_w1", {31'd0, is_write}, 32'd1);
    chk("b2b_a1", {27'd0, wb_addr}, 32'd5);
    chk("b2b_d1", wb_data, 32'h11);
    ex_rd_addr = 5'd6; ex_alu_result = 32'h22;
    @(negedge clk);
    ex_valid = 1'b0;
    chk("b2b_w2", {31'd0, is_write}, 32'd1);
    chk("b2b_a2", {27'd0, wb_addr}, 32'd6);
    chk("b2b_d2", wb_data, 32'h22);
    @(negedge clk);
    chk("b2b_end", {31'd0, is_write}, 32'd0);

    // Misaligned LW
`ifdef MISALIGN_CHECK_EN
    present(1'b1, 1'b0, 3'd2, 32'h402, 32'h0, 1'b1, 5'd12);
    chk("mis_fault", {31'd0, misalign_fault}, 32'd1);
    chk("mis_no_req", {31'd0, dmem_req_valid}, 32'd0);
    chk("mis_no_write", {31'd0, is_write}, 32'd0);
    @(negedge clk);
    chk("mis_pulse", {31'd0, misalign_fault}, 32'd0);
    chk("mis_no_req2", {31'd0, dmem_req_valid}, 32'd0);
    chk("mis_ready", {31'd0, ex_ready}, 32'd1);
    chk("mis_no_write2", {31'd0, is_write}, 32'd0);
`else
    run_op('{1'b1, 1'b0, 3'd2, 32'h402, 32'h0, 32'h0BAD_F00D, 1'b1, 5'd12, 0, 1,
             32'h400, 4'h0, 32'h0, 32'h0BAD_F00D});
`endif

    // Response in the handshake cycle is ignored
    present(1'b1, 1'b0, 3'd2, 32'h700, 32'h0, 1'b1, 5'd13);
    dmem_req_ready = 1'b1; dmem_rsp_valid = 1'b1; dmem_rdata = 32'hBAAD_BAAD;
    @(negedge clk);
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
    chk("hs_rsp_ignored", {31'd0, is_write}, 32'd0);
    @(negedge clk);
    chk("hs_rsp_still_wait", {31'd0, is_write}, 32'd0);
    dmem_rsp_valid = 1'b1; dmem_rdata = 32'h7777_1111;
    @(negedge clk);
    dmem_rsp_valid = 1'b0;
    chk("hs_real_write", {31'd0, is_write}, 32'd1);
    chk("hs_real_data", wb_data, 32'h7777_1111);
    @(negedge clk);

    // Reset while waiting, then a stray response
    present(1'b1, 1'b0, 3'd2, 32'h600, 32'h0, 1'b1, 5'd14);
    dmem_req_ready = 1'b1;
    @(negedge clk);
    dmem_req_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rw_ex_ready", {31'd0, ex_ready}, 32'd0);
    chk("rw_wb_data", wb_data, 32'd0);
    chk("rw_req", {31'd0, dmem_req_valid}, 32'd0);
    rst = 1'b0; dmem_rsp_valid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    dmem_rsp_valid = 1'b0;
    chk("rw_stray_no_write", {31'd0, is_write}, 32'd0);
    chk("rw_idle_ready", {31'd0, ex_ready}, 32'd1);
    @(negedge clk);
    chk("rw_stray_no_write2", {31'd0, is_write}, 32'd0);
    chk("rw_wb_data2", wb_data, 32'd0);

    // Randomized operations against the model
    for (int i = 0; i < 40; i++) begin
      vec_t v;
      int kind;
      logic [1:0] a;
      kind = $urandom_range(0, 2);
      v.word = $urandom; v.sdata = $urandom; v.rd = 5'($urandom_range(1, 31));
      v.we = 1'b1; v.rdy_dly = $urandom_range(0, 2); v.rsp_dly = $urandom_range(1, 3);
      v.addr = $urandom;
      v.ld = (kind == 0); v.st = (kind == 1);
      v.f3 = v.st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      a = v.addr[1:0];
`ifdef MISALIGN_CHECK_EN
      if (v.ld || v.st) begin
        if (v.f3 == 3'd0 || (v.ld && v.f3 == 3'd4)) a = a;
        else if (v.f3 == 3'd1 || (v.ld && v.f3 == 3'd5)) a = a & 2'b10;
        else a = 2'b00;
        v.addr[1:0] = a;
      end
`endif
      if (kind == 2) v.we = 1'($urandom_range(0, 1));
      v.exp_addr  = v.addr - (v.addr % 4);
      v.exp_wstrb = v.st ? m_strb(v.f3, a) : 4'h0;
      v.exp_wdata = v.st ? m_wdata(v.f3, v.sdata) : 32'h0;
      v.exp_wb    = v.ld ? m_load(v.f3, a, v.word) : v.addr;
      run_op(v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
